// File: rtl/move_sequencer_pkg.sv
// rtl/move_sequencer_pkg.sv - shared cell codes, FSM states and helpers for move_sequencer
package move_sequencer_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;
   localparam int         NUM_CELLS  = 9;

   typedef enum logic [1:0] {
      ST_TURN  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic [1:0] other_side(input logic [1:0] side);
      return (side == CELL_X) ? CELL_O : CELL_X;
   endfunction

endpackage

// File: rtl/illegal_hold_timer.sv
// rtl/illegal_hold_timer.sv - reloadable down-counter that stretches the illegal-move flag
module illegal_hold_timer #(
   parameter int HOLD = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic load,
   output logic busy
);

   logic [3:0] count;

   // clear beats load so an accepted move or new game always drops the flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= 4'(HOLD);
      end else if (count != '0) begin
         count <= count - 4'd1;
      end
   end

   assign busy = (count != '0);

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - tic-tac-toe board register and turn sequencer (optional MOVE_COUNT_EN)
module move_sequencer
   import move_sequencer_pkg::*;
#(
   parameter logic [1:0] FIRST_PLAYER = 2'b01,
   parameter int         ILLEGAL_HOLD = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [3:0] move_idx,
   output logic       move_ready,
   input  logic       win,
   input  logic       no_space,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic [1:0] turn,
   output logic [1:0] winner,
   output logic       game_over,
   output logic       illegal_move
`ifdef MOVE_COUNT_EN
   ,
   output logic [3:0] move_count
`endif
);

   state_t                      state, state_next;
   logic [NUM_CELLS-1:0][1:0]   board;
   logic [1:0]                  side;
   logic                        cell_free, accept, reject;

   always_comb begin
      state_next = state;
      move_ready = 1'b0;
      cell_free  = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      // out-of-range indices match no cell and therefore read as occupied
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (move_idx == 4'(i + 1) && board[i] == CELL_EMPTY) cell_free = 1'b1;
      end
      case (state)
         ST_TURN: begin
            move_ready = 1'b1;
            if (move_valid) begin
               if (cell_free) begin
                  accept     = 1'b1;
                  state_next = ST_CHECK;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_CHECK: state_next = (win || no_space) ? ST_DONE : ST_TURN;
         ST_DONE:  state_next = ST_DONE;
         default:  state_next = ST_TURN;
      endcase
      if (new_game) begin
         state_next = ST_TURN;
         accept     = 1'b0;
         reject     = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_TURN;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset || new_game) begin
         board  <= '0;
         side   <= FIRST_PLAYER;
         winner <= CELL_EMPTY;
      end else begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            if (accept && move_idx == 4'(i + 1)) board[i] <= side;
         end
         if (state == ST_CHECK) begin
            if (win)           winner <= side;
            else if (no_space) winner <= CELL_EMPTY;
            else               side   <= other_side(side);
         end
      end
   end

   illegal_hold_timer #(.HOLD(ILLEGAL_HOLD)) u_hold (
      .clock (clock),
      .reset (reset),
      .clear (new_game | accept),
      .load  (reject),
      .busy  (illegal_move)
   );

`ifdef MOVE_COUNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset || new_game)            move_count <= '0;
      else if (accept && move_count < 4'd9) move_count <= move_count + 4'd1;
   end

   a_full_board: assert property (@(posedge clock) disable iff (reset)
      (state == ST_CHECK && no_space) |-> (move_count == 4'd9));
`endif

   assign game_over = (state == ST_DONE);
   assign turn      = (state == ST_DONE) ? CELL_EMPTY : side;
   assign {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = board;

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Board-state register and turn sequencer for the tic-tac-toe game.
- Accepts move requests, checks them, and writes the mover's code into one of nine 2-bit board cells.
- Drives pos1..pos9 straight into the no-space detector and the win detector, then uses their results to decide the next turn or end the game.
- Cell encoding: 2'b00 empty, 2'b01 player X, 2'b10 player O; 2'b11 is never written.

Parameters:
- FIRST_PLAYER, 2'b01: code of the side that moves first after reset or new_game. Legal values are 2'b01 and 2'b10.
- ILLEGAL_HOLD, 4: number of cycles illegal_move stays high after a rejected move. Range 1..15.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- new_game  input  1  synchronous clear of board and FSM; one-cycle pulse
- move_valid  input  1  move request qualifier
- move_idx  input  4  requested cell, 1..9 (row-major, 1 = top-left)
- move_ready  output  1  high when a move can be accepted
- win  input  1  from win detector (combinational on pos*)
- no_space  input  1  from no-space detector
- pos1..pos9  output  2 each  registered board cells
- turn  output  2  side to move (2'b01 or 2'b10); 2'b00 in DONE
- winner  output  2  2'b00 none/draw, else code of winning side; valid in DONE
- game_over  output  1  high in DONE
- illegal_move  output  1  rejected-move indicator

Behaviour:
- Reset (async, active-high):
  - all pos = 2'b00, state = TURN, turn = FIRST_PLAYER
  - winner = 2'b00, game_over = 0, illegal_move = 0, hold counter = 0
- FSM states: TURN, CHECK, DONE.
- TURN:
  - move_ready = 1.
  - On move_valid with move_idx in 1..9 and the target cell 2'b00: cell <= turn at the next edge, state -> CHECK. Move-to-cell latency is 1 cycle.
  - On move_valid with move_idx 0 or 10..15, or an occupied cell: no board change, state stays TURN, turn unchanged. illegal_move rises the next cycle and stays high for exactly ILLEGAL_HOLD cycles.
  - A new illegal request while the hold is active reloads the counter.
  - A legal move during the hold is accepted and clears illegal_move the next cycle.
- CHECK (exactly 1 cycle; detectors see the updated board):
  - move_ready = 0; move_valid is ignored.
  - win = 1: winner <= turn, state -> DONE. Win takes priority over no_space on the last cell.
  - else no_space = 1: winner <= 2'b00, state -> DONE (draw).
  - else: turn <= other side, state -> TURN.
- DONE:
  - game_over = 1, move_ready = 0, turn = 2'b00.
  - Board and winner are held; move_valid is ignored with no illegal_move.
- new_game (any state, synchronous):
  - all pos cleared, winner cleared, illegal_move and its counter cleared
  - turn = FIRST_PLAYER, state -> TURN
  - new_game wins over a simultaneous move_valid, which is dropped.
- reset asserted mid-game, including in CHECK, clears immediately with no partial write.
- pos* are registered only and never combinational from move_idx.
- 2'b11 is never written to any cell.

Optional Feature:
- MOVE_COUNT_EN defined:
  - adds output move_count[3:0]: reset/new_game = 0, +1 on each accepted move, saturates at 9.
  - adds a simulation-only check that move_count == 9 whenever no_space is sampled high in CHECK.
- MOVE_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - cell codes CELL_EMPTY = 2'b00, CELL_X = 2'b01, CELL_O = 2'b10
  - FSM state encodings ST_TURN, ST_CHECK, ST_DONE
  - constant NUM_CELLS = 9
- One natural sub-module: illegal_hold_timer (load, count down, busy output), instantiated once.
- Board write decode stays inline.

Test Plan:
- Reset then X to 5 -> pos5 = 01 one cycle later. CHECK with win = 0, no_space = 0 -> turn = 10, move_ready = 1.
- O requests cell 5 (occupied) -> pos5 stays 01, turn stays 10, illegal_move high for exactly 4 cycles. Repeat at cycle 2 of the hold -> hold extended to 4 cycles from the repeat.
- move_idx = 0 and move_idx = 12 -> illegal_move pulses, board unchanged.
- X plays 1, 2, 3 with O on 4, 5; win driven high in CHECK after X on 3 -> game_over = 1, winner = 01, turn = 00. A later move_valid to 9 is ignored with no illegal_move.
- Fill all 9 cells with no win; no_space = 1 in the final CHECK -> winner = 00, game_over = 1. Same with win = 1 also asserted -> winner = mover.
- new_game and move_valid in the same cycle mid-game -> all pos = 00, turn = FIRST_PLAYER, move dropped. Async reset asserted in CHECK -> outputs clear before the next clock edge.
